// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-ported, handshaked memory bus between the instruction
// fetch port (inst_*) and the data port (mem_*). One access is in flight at
// a time. A bus timeout aborts an access that never sees bus_ack.
// pipe_stall freezes every pipeline stage while any request is outstanding.
//
// Handshake: each requester holds its ren/wen level (and address and data)
// until its ready pulses. Ready is high for exactly one cycle. During that
// cycle the requester retires the request. The same side is not granted
// again in that cycle, so a retiring request is never issued twice.
// On the bus, bus_req and bus_addr/bus_we/bus_wdata stay stable until
// bus_ack. bus_ack is a one-cycle strobe, and bus_rdata is valid with it.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   inst_ren, inst_addr         fetch request and address
//   inst_data, inst_ready       fetched word (registered) and completion pulse
//   mem_ren, mem_wen            data read and write requests (write wins)
//   mem_addr, mem_dout          data address and write data
//   mem_din, mem_ready          read data (registered) and completion pulse
//   bus_req, bus_we             registered bus request and write strobe
//   bus_addr, bus_wdata         registered bus address and write data
//   bus_ack, bus_rdata          memory completion strobe and read data
//   pipe_stall                  combinational stall for the stage enables
//   bus_err, err_addr           sticky timeout flag, first timed-out address
//   dbg_state                   current FSM state (0 IDLE, 1 DATA, 2 INST)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              pipe_stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              bus_req_d, bus_we_d, inst_ready_d, mem_ready_d, bus_err_d;
  logic [ADDR_W-1:0] bus_addr_d, err_addr_d;
  logic [DATA_W-1:0] bus_wdata_d, inst_data_d, mem_din_d;

  logic              data_req;
  logic              timeout_hit;
  logic              finish;
  logic [DATA_W-1:0] ret_data;

  assign data_req    = mem_ren | mem_wen;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_MAX);
  assign pipe_stall  = (data_req & ~mem_ready) | (inst_ren & ~inst_ready);
  assign dbg_state   = state;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bus_req_d    = bus_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    inst_data_d  = inst_data;
    mem_din_d    = mem_din;
    inst_ready_d = 1'b0;
    mem_ready_d  = 1'b0;
    bus_err_d    = bus_err;
    err_addr_d   = err_addr;
    finish       = 1'b0;
    ret_data     = bus_rdata;

    case (state)
      IDLE: begin
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
        // A side whose ready is pulsing this cycle is retiring its request.
        if (data_req && !mem_ready) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_wen;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_dout;
          cnt_d       = '0;
          state_d     = DATA;
        end else if (inst_ren && !inst_ready) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = inst_addr;
          cnt_d      = '0;
          state_d    = INST;
        end
      end
      DATA, INST: begin
        // An ack in the expiry cycle wins over the timeout.
        if (bus_ack) begin
          finish = 1'b1;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          ret_data = '1;
          bus_err_d = 1'b1;
          if (!bus_err) err_addr_d = bus_addr;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt + 1'b1;
        end
        if (finish) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = IDLE;
          if (state == DATA) begin
            mem_ready_d = 1'b1;
            if (!bus_we) mem_din_d = ret_data;
          end else begin
            inst_ready_d = 1'b1;
            inst_data_d  = ret_data;
          end
        end
      end
      default: begin
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_data  <= '0;
      mem_din    <= '0;
      inst_ready <= 1'b0;
      mem_ready  <= 1'b0;
      bus_err    <= 1'b0;
      err_addr   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      inst_data  <= inst_data_d;
      mem_din    <= mem_din_d;
      inst_ready <= inst_ready_d;
      mem_ready  <= mem_ready_d;
      bus_err    <= bus_err_d;
      err_addr   <= err_addr_d;
    end
  end

endmodule
